multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter: RETIRE_W, default 32, width of retired-instruction counter.
REQ-002 Clocking: one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 opcode  input  6  IR[31:26], stable from DECODE until next FETCH.
REQ-006 funct  input  6  IR[5:0], same stability as opcode.
REQ-007 Zero  input  1  ALU zero flag, combinational from ALU.
REQ-008 imem_ready  input  1  instruction memory data valid this cycle.
REQ-009 imem_req  output  1  fetch request.
REQ-010 IR_Write, PC_Write, Target_Write, RegWrite, RegDst, ALUSrcA  output  1 each  datapath enables/selects.
REQ-011 ALUSrcB  output  2  00 reg B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2.
REQ-012 ALU_OP  output  3  000 add, 001 subtract; no other code driven.
REQ-013 PCSource  output  2  00 ALU result, 01 Target register, 10 jump address.
REQ-014 state  output  3  current FSM state code.
REQ-015 illegal  output  1  sticky illegal-opcode flag.
REQ-016 retired  output  RETIRE_W  count of completed instructions.

Function
REQ-017 States/codes: FETCH 0, DECODE 1, EXEC_R 2, EXEC_I 3, WB 4, BRANCH 5, JUMP 6, TRAP 7.
REQ-018 Outputs not listed for a state SHALL be 0.
REQ-019 FETCH: imem_req=1, ALUSrcA=0, ALUSrcB=01, ALU_OP=000, PCSource=00; IR_Write=PC_Write=imem_ready (Mealy); to DECODE when imem_ready, else hold.
REQ-020 DECODE: ALUSrcA=0, ALUSrcB=11, ALU_OP=000, Target_Write=1; latch class; next: opcode 000000 with funct 100000/100010 -> EXEC_R, 001000 -> EXEC_I, 000100/000101 -> BRANCH, 000010 -> JUMP, anything else -> TRAP.
REQ-021 EXEC_R: ALUSrcA=1, ALUSrcB=00, ALU_OP=000 for funct 100000, 001 for 100010; -> WB.
REQ-022 EXEC_I: ALUSrcA=1, ALUSrcB=10, ALU_OP=000; -> WB.
REQ-023 WB: RegWrite=1, RegDst=1 if latched class R else 0; -> FETCH.
REQ-024 BRANCH: ALUSrcA=1, ALUSrcB=00, ALU_OP=001, PCSource=01; PC_Write=Zero for beq, ~Zero for bne (Mealy, same cycle); -> FETCH.
REQ-025 JUMP: PCSource=10, PC_Write=1; -> FETCH.
REQ-026 TRAP: all enables 0, illegal=1; remain until reset.
REQ-027 Latency: R/addi 4 cycles, beq/bne/j 3 cycles, each plus FETCH wait cycles.
REQ-028 retired increments by 1 on the clock edge leaving WB, BRANCH or JUMP, whether or not the branch is taken; wraps modulo 2^RETIRE_W.
REQ-029 illegal sets on entry to TRAP; it is never cleared except by reset.
REQ-030 imem_ready outside FETCH SHALL be ignored.

Reset
REQ-031 rst_n low SHALL immediately force state=FETCH, retired=0, illegal=0, latched class=R, without waiting for clk.
REQ-032 All outputs, including imem_req, SHALL be 0 while rst_n is low.
REQ-033 Reset mid-instruction SHALL abandon it; retired does not count it.
REQ-034 The first FETCH cycle follows the first rising clk edge after rst_n deasserts.

Verification
REQ-035 addi (opcode 001000), imem_ready=1 throughout -> state 0,1,3,4,0; RegWrite=1 only in WB with RegDst=0; retired 0->1.
REQ-036 R sub (funct 100010) -> ALU_OP=001 in EXEC_R; RegDst=1 in WB; 4 cycles total.
REQ-037 beq with Zero=1 -> PC_Write=1, PCSource=01 in BRANCH; bne with Zero=1 -> PC_Write=0; retired increments by 1 in both cases.
REQ-038 imem_ready low 3 cycles in FETCH -> state holds 0, IR_Write=PC_Write=0; then advances on the cycle imem_ready goes high.
REQ-039 opcode 111111 -> TRAP, illegal=1 held for 10 or more cycles, no enables; rst_n pulse between clock edges -> state=0, illegal=0 immediately.
REQ-040 retired preloaded near wrap (RETIRE_W=4, 15 instructions run, then one more) -> retired reads 15, then 0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle CPU control FSM with retire counter and sticky illegal-opcode trap
module multicycle_ctrl #(
   parameter int RETIRE_W = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [5:0]          opcode,
   input  logic [5:0]          funct,
   input  logic                Zero,
   input  logic                imem_ready,
   output logic                imem_req,
   output logic                IR_Write,
   output logic                PC_Write,
   output logic                Target_Write,
   output logic                RegWrite,
   output logic                RegDst,
   output logic                ALUSrcA,
   output logic [1:0]          ALUSrcB,
   output logic [2:0]          ALU_OP,
   output logic [1:0]          PCSource,
   output logic [2:0]          state,
   output logic                illegal,
   output logic [RETIRE_W-1:0] retired
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC_R = 3'd2,
      S_EXEC_I = 3'd3,
      S_WB     = 3'd4,
      S_BRANCH = 3'd5,
      S_JUMP   = 3'd6,
      S_TRAP   = 3'd7
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] FN_ADD   = 6'b100000;
   localparam logic [5:0] FN_SUB   = 6'b100010;

   localparam logic [RETIRE_W-1:0] RETIRE_ONE = {{(RETIRE_W-1){1'b0}}, 1'b1};

   state_t              state_q, state_d;
   logic                run_q, run_d;
   logic                class_r_q, class_r_d;
   logic                illegal_q, illegal_d;
   logic [RETIRE_W-1:0] retired_q, retired_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_FETCH;
         run_q     <= 1'b0;
         class_r_q <= 1'b1;
         illegal_q <= 1'b0;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         run_q     <= run_d;
         class_r_q <= class_r_d;
         illegal_q <= illegal_d;
         retired_q <= retired_d;
      end
   end

   // run_q holds every output low until the first clock edge after reset releases
   always_comb begin
      state_d      = state_q;
      run_d        = 1'b1;
      class_r_d    = class_r_q;
      retired_d    = retired_q;
      imem_req     = 1'b0;
      IR_Write     = 1'b0;
      PC_Write     = 1'b0;
      Target_Write = 1'b0;
      RegWrite     = 1'b0;
      RegDst       = 1'b0;
      ALUSrcA      = 1'b0;
      ALUSrcB      = 2'b00;
      ALU_OP       = 3'b000;
      PCSource     = 2'b00;
      if (run_q) begin
         case (state_q)
            S_FETCH: begin
               imem_req = 1'b1;
               ALUSrcB  = 2'b01;
               IR_Write = imem_ready;
               PC_Write = imem_ready;
               if (imem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
               ALUSrcB      = 2'b11;
               Target_Write = 1'b1;
               if (opcode == OP_RTYPE && (funct == FN_ADD || funct == FN_SUB)) begin
                  state_d   = S_EXEC_R;
                  class_r_d = 1'b1;
               end else if (opcode == OP_ADDI) begin
                  state_d   = S_EXEC_I;
                  class_r_d = 1'b0;
               end else if (opcode == OP_BEQ || opcode == OP_BNE) begin
                  state_d = S_BRANCH;
               end else if (opcode == OP_J) begin
                  state_d = S_JUMP;
               end else begin
                  state_d = S_TRAP;
               end
            end
            S_EXEC_R: begin
               ALUSrcA = 1'b1;
               ALU_OP  = (funct == FN_SUB) ? 3'b001 : 3'b000;
               state_d = S_WB;
            end
            S_EXEC_I: begin
               ALUSrcA = 1'b1;
               ALUSrcB = 2'b10;
               state_d = S_WB;
            end
            S_WB: begin
               RegWrite  = 1'b1;
               RegDst    = class_r_q;
               state_d   = S_FETCH;
               retired_d = retired_q + RETIRE_ONE;
            end
            S_BRANCH: begin
               ALUSrcA   = 1'b1;
               ALU_OP    = 3'b001;
               PCSource  = 2'b01;
               PC_Write  = (opcode == OP_BNE) ? ~Zero : Zero;
               state_d   = S_FETCH;
               retired_d = retired_q + RETIRE_ONE;
            end
            S_JUMP: begin
               PCSource  = 2'b10;
               PC_Write  = 1'b1;
               state_d   = S_FETCH;
               retired_d = retired_q + RETIRE_ONE;
            end
            default: state_d = S_TRAP;
         endcase
      end
      illegal_d = illegal_q | (state_d == S_TRAP);
   end

   assign state   = state_q;
   assign illegal = illegal_q;
   assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - directed self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;

   localparam int RW = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [5:0]    opcode;
   logic [5:0]    funct;
   logic          zero;
   logic          imem_ready;
   logic          imem_req, ir_write, pc_write, target_write, reg_write, reg_dst, alu_src_a;
   logic [1:0]    alu_src_b;
   logic [2:0]    alu_op;
   logic [1:0]    pc_source;
   logic [2:0]    state;
   logic          illegal;
   logic [RW-1:0] retired;

   int n_chk  = 0;
   int n_fail = 0;

   multicycle_ctrl #(.RETIRE_W(RW)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .Zero(zero),
      .imem_ready(imem_ready), .imem_req(imem_req), .IR_Write(ir_write),
      .PC_Write(pc_write), .Target_Write(target_write), .RegWrite(reg_write),
      .RegDst(reg_dst), .ALUSrcA(alu_src_a), .ALUSrcB(alu_src_b), .ALU_OP(alu_op),
      .PCSource(pc_source), .state(state), .illegal(illegal), .retired(retired)
   );

   always #5 clk = ~clk;

   // {imem_req, IR_Write, PC_Write, Target_Write, RegWrite, RegDst, ALUSrcA}
   wire [6:0] en = {imem_req, ir_write, pc_write, target_write, reg_write, reg_dst, alu_src_a};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_jump();
      opcode = 6'b000010;
      tick();
      tick();
      tick();
   endtask

   initial begin
      rst_n      = 1'b0;
      opcode     = 6'b001000;
      funct      = 6'b000000;
      zero       = 1'b0;
      imem_ready = 1'b1;
      #3;
      chk("rst_state", state, 3'd0);
      chk("rst_en", en, 7'b0);
      chk("rst_retired", retired, 0);
      chk("rst_illegal", illegal, 0);
      @(posedge clk);
      #2 rst_n = 1'b1;
      #1 chk("post_rel_no_req", imem_req, 0);

      // addi
      tick();
      chk("addi_f_state", state, 0);
      chk("addi_f_en", en, 7'b1110000);
      chk("addi_f_srcb", alu_src_b, 2'b01);
      tick();
      chk("addi_d_state", state, 1);
      chk("addi_d_en", en, 7'b0001000);
      chk("addi_d_srcb", alu_src_b, 2'b11);
      tick();
      chk("addi_x_state", state, 3);
      chk("addi_x_en", en, 7'b0000001);
      chk("addi_x_srcb", alu_src_b, 2'b10);
      tick();
      chk("addi_wb_state", state, 4);
      chk("addi_wb_en", en, 7'b0000100);
      chk("addi_wb_ret", retired, 0);
      tick();
      chk("addi_done_state", state, 0);
      chk("addi_done_ret", retired, 1);

      // R-type sub
      opcode = 6'b000000;
      funct  = 6'b100010;
      tick();
      tick();
      chk("sub_x_state", state, 2);
      chk("sub_x_aluop", alu_op, 3'b001);
      chk("sub_x_srcb", alu_src_b, 2'b00);
      chk("sub_x_en", en, 7'b0000001);
      tick();
      chk("sub_wb_en", en, 7'b0000110);
      tick();
      chk("sub_done_ret", retired, 2);

      // beq taken
      opcode = 6'b000100;
      zero   = 1'b1;
      tick();
      tick();
      chk("beq_state", state, 5);
      chk("beq_pcw", pc_write, 1);
      chk("beq_pcsrc", pc_source, 2'b01);
      chk("beq_aluop", alu_op, 3'b001);
      tick();
      chk("beq_ret", retired, 3);

      // bne with Zero=1 then Zero=0 in the same cycle
      opcode = 6'b000101;
      tick();
      tick();
      chk("bne_z1_pcw", pc_write, 0);
      chk("bne_pcsrc", pc_source, 2'b01);
      zero = 1'b0;
      #1 chk("bne_z0_pcw", pc_write, 1);
      tick();
      chk("bne_ret", retired, 4);

      // fetch stall then jump
      opcode     = 6'b000010;
      imem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1 chk("stall_state", state, 0);
         chk("stall_en", en, 7'b1000000);
         tick();
      end
      chk("stall_still_fetch", state, 0);
      imem_ready = 1'b1;
      #1 chk("stall_release_en", en, 7'b1110000);
      tick();
      chk("stall_decode", state, 1);
      imem_ready = 1'b0;
      tick();
      chk("jump_state", state, 6);
      chk("jump_en", en, 7'b0010000);
      chk("jump_pcsrc", pc_source, 2'b10);
      imem_ready = 1'b1;
      tick();
      chk("jump_ret", retired, 5);

      // retire counter wrap
      for (int i = 0; i < 10; i++) run_jump();
      chk("wrap_15", retired, 15);
      run_jump();
      chk("wrap_0", retired, 0);

      // illegal opcode trap
      opcode = 6'b111111;
      tick();
      tick();
      chk("trap_state", state, 7);
      chk("trap_illegal", illegal, 1);
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("trap_hold_state", state, 7);
         chk("trap_hold_en", {en, alu_src_b, alu_op, pc_source}, 0);
         chk("trap_hold_illegal", illegal, 1);
      end
      #1 rst_n = 1'b0;
      #1 chk("async_rst_state", state, 0);
      chk("async_rst_illegal", illegal, 0);
      chk("async_rst_en", en, 7'b0);
      #1 rst_n = 1'b1;
      #1 chk("async_rel_no_req", imem_req, 0);

      // opcode 0 with unsupported funct traps; reset mid-instruction
      opcode = 6'b000000;
      funct  = 6'b100100;
      tick();
      chk("ufn_fetch", state, 0);
      tick();
      tick();
      chk("ufn_trap", state, 7);
      #1 rst_n = 1'b0;
      #1 rst_n = 1'b1;
      opcode = 6'b001000;
      tick();
      tick();
      tick();
      chk("mid_exec", state, 3);
      #1 rst_n = 1'b0;
      #1 chk("mid_rst_ret", retired, 0);
      rst_n = 1'b1;
      tick();
      chk("mid_rst_fetch", state, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
